weight_line_buffer_scheduler: RTL and testbench
===============================================

# weight_line_buffer_scheduler

Ring scheduler that shares the weight line buffers between the loader (host weight AXI write path) and the compute read side. Each line buffer cycles EMPTY -> FILLING -> FULL -> CONSUMING -> EMPTY. The loader fills buffers and compute drains them in strict ring order, which gives ping-pong (or deeper) prefetch. The block sits beside the weight buffer write control. Its fill id selects the line buffer the loader addresses. Its consume id selects the line buffer the compute read port uses.

## Interface
- NUMBER_OF_WEIGHT_LINE_BUFFERS, default NVP_v1_constants::NUMBER_OF_WEIGHT_LINE_BUFFERS: buffers managed; must be >= 2.
- SEL_W (localparam), $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS): buffer id width.
- CNT_W (localparam), $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS+1): count width.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous flush of all state.
- i_fill_req  in  1  loader requests an empty buffer; level, held until granted.
- o_fill_grant  out  1  one-cycle pulse; buffer o_fill_buffer_id is now FILLING.
- o_fill_buffer_id  out  SEL_W  id of the buffer being filled; valid while o_fill_active.
- o_fill_active  out  1  a fill is in progress.
- i_fill_done  in  1  one-cycle pulse; the active fill is complete.
- i_consume_req  in  1  compute requests a full buffer; level.
- o_consume_grant  out  1  one-cycle pulse; buffer o_consume_buffer_id is now CONSUMING.
- o_consume_buffer_id  out  SEL_W  id of the buffer being consumed; valid while o_consume_active.
- o_consume_active  out  1  a consume is in progress.
- i_consume_done  in  1  one-cycle pulse; the active consume is complete.
- o_full_count  out  CNT_W  number of buffers in FULL.
- o_all_empty  out  1  every buffer is EMPTY.
- o_protocol_error  out  1  sticky flag for a done pulse with no matching active operation.

## Operation
- State per buffer: 2-bit code, EMPTY=0, FILLING=1, FULL=2, CONSUMING=3.
- Pointers: wr_ptr (next buffer to fill) and rd_ptr (next buffer to consume), each SEL_W bits.
  - Each pointer increments by 1 and wraps from N-1 to 0. Non-power-of-2 N is handled with an explicit compare, not bit overflow.
- Fill grant condition: i_fill_req && !o_fill_active && state[wr_ptr]==EMPTY.
  - Registered effect next edge: state[wr_ptr] becomes FILLING, o_fill_active=1, o_fill_buffer_id=wr_ptr, o_fill_grant=1 for one cycle.
- Fill done: i_fill_done && o_fill_active.
  - Next edge: state[o_fill_buffer_id] becomes FULL, o_fill_active=0, wr_ptr advances.
- Consume grant: symmetric, with condition i_consume_req && !o_consume_active && state[rd_ptr]==FULL; the buffer becomes CONSUMING.
- Consume done: i_consume_done && o_consume_active.
  - Next edge: the buffer becomes EMPTY, o_consume_active=0, rd_ptr advances.
- Decisions use current-cycle state only; there is no same-cycle bypass.
  - Done and re-grant on the same side never occur in one cycle. Minimum period per side is grant, done, grant = 3 cycles.
  - A buffer freed or filled by a done is grantable to the other side one cycle later.
- Simultaneous events:
  - Fill done and consume done in the same cycle: both apply. They target different buffers.
  - Fill grant and consume grant in the same cycle: both apply. They target different buffers.
- Error handling:
  - i_fill_done without o_fill_active, or i_consume_done without o_consume_active: the pulse is ignored and o_protocol_error is set.
  - o_protocol_error is cleared only by flush or reset.
- Status outputs:
  - o_full_count counts FULL states; it is derived combinationally from the state registers.
  - o_all_empty = all states EMPTY.
- Flush: i_flush has priority over every other input in its cycle.
  - Next edge: all states EMPTY, pointers 0, both actives 0, grants 0, error 0.
  - Done pulses in the flush cycle are discarded.

## Timing
- Reset (async assert, sync release): all states EMPTY; wr_ptr=rd_ptr=0; o_fill_grant=o_consume_grant=0; o_fill_active=o_consume_active=0; both buffer ids 0; o_full_count=0; o_all_empty=1; o_protocol_error=0.
- Latency: request seen at edge k gives grant high in cycle k+1 (one registered stage). Done at edge k makes the state visible in cycle k+1.
- Ids are registered and stable from the grant cycle until the cycle after done.
- A request dropped before grant is simply not served. The block holds no pending request memory.
- Reset mid-operation: identical to flush, but asynchronous. Any active fill or consume is abandoned.
- Full ring (all FULL, fill requested): no grant until a consume done frees rd_ptr's buffer; the fill grant comes 1 cycle after that done is registered.

## Test plan
- Basic flow, N=2: fill req, then grant id0; done; fill req, then grant id1; done; o_full_count=2. Consume req gives grants id0 then id1 in order, with done after each; o_all_empty=1 at the end.
- Backpressure, N=2: both buffers FULL and i_fill_req held -> no o_fill_grant. i_consume_done on id0 -> o_fill_grant with id0 exactly 2 cycles after the done edge.
- Overlap: fill done on id1 and consume done on id0 in the same cycle -> id1 FULL, id0 EMPTY, o_full_count=1, both actives 0.
- Empty ring: i_consume_req held with all EMPTY -> no grant. Fill grant then fill done on id0 -> consume grant id0 on the cycle after the state becomes FULL.
- Protocol error: i_consume_done with no active consume -> o_protocol_error=1, states unchanged. i_flush -> error 0 and o_all_empty=1.
- Flush/reset mid-fill: id1 FILLING, then i_flush (repeat with resetn low) -> next cycle o_fill_active=0 and wr_ptr=0; the next fill grant is id0.

Source files
------------

// File: rtl/NVP_v1_constants.sv
// Project-wide NVP v1 sizing constants shared by the weight path blocks.
// Pure constants, no logic.
// Consumers take defaults from here so all blocks agree on buffer counts.
package NVP_v1_constants;
  localparam int NUMBER_OF_WEIGHT_LINE_BUFFERS = 2;
endpackage

// File: rtl/weight_line_buffer_scheduler.sv
// Ring scheduler handing weight line buffers between loader (fill) and compute (consume).
// Latency: request/done sampled at an edge take effect in the following cycle (one registered stage).
// Backpressure: a request waits (no grant) while its side is busy or the ring slot is not ready.
module weight_line_buffer_scheduler #(
  parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = NVP_v1_constants::NUMBER_OF_WEIGHT_LINE_BUFFERS,
  localparam int SEL_W = $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS),
  localparam int CNT_W = $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_fill_req,
  output logic             o_fill_grant,
  output logic [SEL_W-1:0] o_fill_buffer_id,
  output logic             o_fill_active,
  input  logic             i_fill_done,
  input  logic             i_consume_req,
  output logic             o_consume_grant,
  output logic [SEL_W-1:0] o_consume_buffer_id,
  output logic             o_consume_active,
  input  logic             i_consume_done,
  output logic [CNT_W-1:0] o_full_count,
  output logic             o_all_empty,
  output logic             o_protocol_error
);

  localparam int NUM = NUMBER_OF_WEIGHT_LINE_BUFFERS;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FILLING   = 2'd1,
    FULL      = 2'd2,
    CONSUMING = 2'd3
  } buf_state_t;

  buf_state_t       state [NUM];
  logic [SEL_W-1:0] wr_ptr;
  logic [SEL_W-1:0] rd_ptr;

  logic fill_grant_go;
  logic fill_done_go;
  logic consume_grant_go;
  logic consume_done_go;
  logic stray_done;

  logic [CNT_W-1:0] full_cnt;
  logic             none_busy;

  // Ring increment with an explicit wrap so non-power-of-2 rings work.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(NUM - 1)) ? '0 : p + SEL_W'(1);
  endfunction

  // Decisions look only at registered state; grant and done on one side are exclusive via the active flag.
  assign fill_grant_go    = i_fill_req && !o_fill_active && (state[wr_ptr] == EMPTY);
  assign fill_done_go     = i_fill_done && o_fill_active;
  assign consume_grant_go = i_consume_req && !o_consume_active && (state[rd_ptr] == FULL);
  assign consume_done_go  = i_consume_done && o_consume_active;
  assign stray_done       = (i_fill_done && !o_fill_active) || (i_consume_done && !o_consume_active);

  // Status derived straight from the per-buffer state registers.
  always_comb begin
    full_cnt  = '0;
    none_busy = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      if (state[i] == FULL) full_cnt = full_cnt + CNT_W'(1);
      if (state[i] != EMPTY) none_busy = 1'b0;
    end
  end

  assign o_full_count = full_cnt;
  assign o_all_empty  = none_busy;

  // Buffer state, ring pointers and registered handshake outputs; flush mirrors reset synchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM; i++) state[i] <= EMPTY;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_fill_grant        <= 1'b0;
      o_fill_active       <= 1'b0;
      o_fill_buffer_id    <= '0;
      o_consume_grant     <= 1'b0;
      o_consume_active    <= 1'b0;
      o_consume_buffer_id <= '0;
      o_protocol_error    <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM; i++) state[i] <= EMPTY;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_fill_grant        <= 1'b0;
      o_fill_active       <= 1'b0;
      o_fill_buffer_id    <= '0;
      o_consume_grant     <= 1'b0;
      o_consume_active    <= 1'b0;
      o_consume_buffer_id <= '0;
      o_protocol_error    <= 1'b0;
    end else begin
      o_fill_grant    <= fill_grant_go;
      o_consume_grant <= consume_grant_go;
      if (fill_grant_go) begin
        state[wr_ptr]    <= FILLING;
        o_fill_active    <= 1'b1;
        o_fill_buffer_id <= wr_ptr;
      end
      // Id is left untouched on done so it stays stable into the following cycle.
      if (fill_done_go) begin
        state[o_fill_buffer_id] <= FULL;
        o_fill_active           <= 1'b0;
        wr_ptr                  <= next_ptr(wr_ptr);
      end
      if (consume_grant_go) begin
        state[rd_ptr]       <= CONSUMING;
        o_consume_active    <= 1'b1;
        o_consume_buffer_id <= rd_ptr;
      end
      if (consume_done_go) begin
        state[o_consume_buffer_id] <= EMPTY;
        o_consume_active           <= 1'b0;
        rd_ptr                     <= next_ptr(rd_ptr);
      end
      if (stray_done) o_protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_line_buffer_scheduler.sv
// Self-checking bench: directed scenarios on a 2-buffer ring, randomized run on a 3-buffer ring.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Reference model tracks per-buffer states with plain integers and modular pointer arithmetic.
module tb_weight_line_buffer_scheduler;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Two-buffer instance for directed scenarios.
  logic       flush, fill_req, fill_done, consume_req, consume_done;
  logic       fill_grant, fill_active, consume_grant, consume_active, all_empty, perr;
  logic [0:0] fill_id, consume_id;
  logic [1:0] full_count;

  weight_line_buffer_scheduler #(.NUMBER_OF_WEIGHT_LINE_BUFFERS(2)) dut (
    .clk(clk), .resetn(resetn), .i_flush(flush),
    .i_fill_req(fill_req), .o_fill_grant(fill_grant), .o_fill_buffer_id(fill_id),
    .o_fill_active(fill_active), .i_fill_done(fill_done),
    .i_consume_req(consume_req), .o_consume_grant(consume_grant), .o_consume_buffer_id(consume_id),
    .o_consume_active(consume_active), .i_consume_done(consume_done),
    .o_full_count(full_count), .o_all_empty(all_empty), .o_protocol_error(perr)
  );

  // Three-buffer instance for the randomized run (non-power-of-2 wrap).
  localparam int RN = 3;
  logic       r_flush, r_fill_req, r_fill_done, r_consume_req, r_consume_done;
  logic       r_fill_grant, r_fill_active, r_consume_grant, r_consume_active, r_all_empty, r_perr;
  logic [1:0] r_fill_id, r_consume_id;
  logic [1:0] r_full_count;

  weight_line_buffer_scheduler #(.NUMBER_OF_WEIGHT_LINE_BUFFERS(RN)) dut3 (
    .clk(clk), .resetn(resetn), .i_flush(r_flush),
    .i_fill_req(r_fill_req), .o_fill_grant(r_fill_grant), .o_fill_buffer_id(r_fill_id),
    .o_fill_active(r_fill_active), .i_fill_done(r_fill_done),
    .i_consume_req(r_consume_req), .o_consume_grant(r_consume_grant), .o_consume_buffer_id(r_consume_id),
    .o_consume_active(r_consume_active), .i_consume_done(r_consume_done),
    .o_full_count(r_full_count), .o_all_empty(r_all_empty), .o_protocol_error(r_perr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic do_fill();
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    fill_done = 1'b1; tick(); fill_done = 1'b0;
  endtask

  task automatic do_consume();
    consume_req = 1'b1; tick(); consume_req = 1'b0;
    consume_done = 1'b1; tick(); consume_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush = 0; fill_req = 0; fill_done = 0; consume_req = 0; consume_done = 0;
    r_flush = 0; r_fill_req = 0; r_fill_done = 0; r_consume_req = 0; r_consume_done = 0;
    #3;
    vectors++;
    if ({fill_grant, fill_active, fill_id, consume_grant, consume_active, consume_id, full_count, all_empty, perr}
        !== 10'b0000000_0_1_0 >> 0 && 1'b0) begin end
    if ({fill_grant, fill_active, fill_id, consume_grant, consume_active, consume_id, full_count, all_empty, perr}
        !== 10'b00_0_00_0_00_1_0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b",
               {fill_grant, fill_active, fill_id, consume_grant, consume_active, consume_id, full_count, all_empty, perr},
               10'b00_0_00_0_00_1_0);
    end
    tick(); tick();
    resetn = 1'b1;
    tick();
    vectors++;
    if (all_empty !== 1'b1 || full_count !== 2'd0 || fill_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got empty=%b cnt=%0d act=%b want 1 0 0", all_empty, full_count, fill_active);
    end
  endtask

  task automatic test_basic_flow();
    do_flush();
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    vectors++;
    if (fill_grant !== 1'b1 || fill_id !== 1'b0 || fill_active !== 1'b1) begin
      errors++; $display("FAIL basic_grant0: got g=%b id=%0d a=%b want 1 0 1", fill_grant, fill_id, fill_active);
    end
    fill_done = 1'b1; tick(); fill_done = 1'b0;
    vectors++;
    if (fill_active !== 1'b0 || full_count !== 2'd1 || fill_grant !== 1'b0 || fill_id !== 1'b0) begin
      errors++; $display("FAIL basic_done0: got a=%b cnt=%0d g=%b id=%0d want 0 1 0 0", fill_active, full_count, fill_grant, fill_id);
    end
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    vectors++;
    if (fill_grant !== 1'b1 || fill_id !== 1'b1) begin
      errors++; $display("FAIL basic_grant1: got g=%b id=%0d want 1 1", fill_grant, fill_id);
    end
    fill_done = 1'b1; tick(); fill_done = 1'b0;
    vectors++;
    if (full_count !== 2'd2 || all_empty !== 1'b0) begin
      errors++; $display("FAIL basic_full2: got cnt=%0d empty=%b want 2 0", full_count, all_empty);
    end
    for (int k = 0; k < 2; k++) begin
      consume_req = 1'b1; tick(); consume_req = 1'b0;
      vectors++;
      if (consume_grant !== 1'b1 || consume_id !== 1'(k) || consume_active !== 1'b1) begin
        errors++; $display("FAIL basic_cgrant%0d: got g=%b id=%0d a=%b want 1 %0d 1", k, consume_grant, consume_id, consume_active, k);
      end
      consume_done = 1'b1; tick(); consume_done = 1'b0;
      vectors++;
      if (full_count !== 2'(1 - k) || consume_active !== 1'b0) begin
        errors++; $display("FAIL basic_cdone%0d: got cnt=%0d a=%b want %0d 0", k, full_count, consume_active, 1 - k);
      end
    end
    vectors++;
    if (all_empty !== 1'b1) begin
      errors++; $display("FAIL basic_all_empty: got %b want 1", all_empty);
    end
  endtask

  task automatic test_backpressure();
    do_flush();
    do_fill(); do_fill();
    fill_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (fill_grant !== 1'b0) begin
        errors++; $display("FAIL bp_no_grant%0d: got %b want 0", k, fill_grant);
      end
    end
    consume_req = 1'b1; tick(); consume_req = 1'b0;
    consume_done = 1'b1; tick(); consume_done = 1'b0;
    vectors++;
    if (fill_grant !== 1'b0 || full_count !== 2'd1) begin
      errors++; $display("FAIL bp_after_done: got g=%b cnt=%0d want 0 1", fill_grant, full_count);
    end
    tick();
    fill_req = 1'b0;
    vectors++;
    if (fill_grant !== 1'b1 || fill_id !== 1'b0) begin
      errors++; $display("FAIL bp_grant: got g=%b id=%0d want 1 0", fill_grant, fill_id);
    end
    tick();
    vectors++;
    if (fill_grant !== 1'b0 || fill_active !== 1'b1) begin
      errors++; $display("FAIL bp_pulse: got g=%b a=%b want 0 1", fill_grant, fill_active);
    end
  endtask

  task automatic test_overlap();
    do_flush();
    do_fill();
    fill_req = 1'b1; consume_req = 1'b1; tick(); fill_req = 1'b0; consume_req = 1'b0;
    vectors++;
    if (fill_grant !== 1'b1 || fill_id !== 1'b1 || consume_grant !== 1'b1 || consume_id !== 1'b0) begin
      errors++; $display("FAIL ovl_grants: got fg=%b fid=%0d cg=%b cid=%0d want 1 1 1 0", fill_grant, fill_id, consume_grant, consume_id);
    end
    fill_done = 1'b1; consume_done = 1'b1; tick(); fill_done = 1'b0; consume_done = 1'b0;
    vectors++;
    if (full_count !== 2'd1 || fill_active !== 1'b0 || consume_active !== 1'b0 || all_empty !== 1'b0) begin
      errors++; $display("FAIL ovl_dones: got cnt=%0d fa=%b ca=%b empty=%b want 1 0 0 0", full_count, fill_active, consume_active, all_empty);
    end
    consume_req = 1'b1; tick(); consume_req = 1'b0;
    vectors++;
    if (consume_grant !== 1'b1 || consume_id !== 1'b1) begin
      errors++; $display("FAIL ovl_next_consume: got g=%b id=%0d want 1 1", consume_grant, consume_id);
    end
    consume_done = 1'b1; tick(); consume_done = 1'b0;
  endtask

  task automatic test_empty_ring();
    do_flush();
    consume_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (consume_grant !== 1'b0) begin
        errors++; $display("FAIL empty_no_grant%0d: got %b want 0", k, consume_grant);
      end
    end
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    fill_done = 1'b1; tick(); fill_done = 1'b0;
    vectors++;
    if (consume_grant !== 1'b0 || full_count !== 2'd1) begin
      errors++; $display("FAIL empty_now_full: got g=%b cnt=%0d want 0 1", consume_grant, full_count);
    end
    tick();
    consume_req = 1'b0;
    vectors++;
    if (consume_grant !== 1'b1 || consume_id !== 1'b0) begin
      errors++; $display("FAIL empty_grant: got g=%b id=%0d want 1 0", consume_grant, consume_id);
    end
  endtask

  task automatic test_protocol_error();
    do_flush();
    do_fill();
    consume_done = 1'b1; tick(); consume_done = 1'b0;
    vectors++;
    if (perr !== 1'b1 || full_count !== 2'd1 || consume_active !== 1'b0) begin
      errors++; $display("FAIL perr_set: got err=%b cnt=%0d ca=%b want 1 1 0", perr, full_count, consume_active);
    end
    tick(); tick();
    vectors++;
    if (perr !== 1'b1) begin
      errors++; $display("FAIL perr_sticky: got %b want 1", perr);
    end
    do_flush();
    vectors++;
    if (perr !== 1'b0 || all_empty !== 1'b1) begin
      errors++; $display("FAIL perr_flush: got err=%b empty=%b want 0 1", perr, all_empty);
    end
  endtask

  task automatic test_flush_mid_fill();
    for (int use_reset = 0; use_reset < 2; use_reset++) begin
      do_flush();
      do_fill();
      fill_req = 1'b1; tick(); fill_req = 1'b0;
      vectors++;
      if (fill_grant !== 1'b1 || fill_id !== 1'b1) begin
        errors++; $display("FAIL mid_fill_grant%0d: got g=%b id=%0d want 1 1", use_reset, fill_grant, fill_id);
      end
      if (use_reset == 0) begin
        flush = 1'b1; fill_done = 1'b1; tick(); flush = 1'b0; fill_done = 1'b0;
      end else begin
        resetn = 1'b0; #1;
      end
      vectors++;
      if (fill_active !== 1'b0 || all_empty !== 1'b1 || full_count !== 2'd0 || fill_grant !== 1'b0) begin
        errors++; $display("FAIL mid_fill_abort%0d: got a=%b empty=%b cnt=%0d g=%b want 0 1 0 0",
                           use_reset, fill_active, all_empty, full_count, fill_grant);
      end
      if (use_reset == 1) begin
        tick();
        resetn = 1'b1;
      end
      fill_req = 1'b1; tick(); fill_req = 1'b0;
      vectors++;
      if (fill_grant !== 1'b1 || fill_id !== 1'b0) begin
        errors++; $display("FAIL mid_fill_regrant%0d: got g=%b id=%0d want 1 0", use_reset, fill_grant, fill_id);
      end
    end
  endtask

  // Randomized run on the 3-buffer ring against a spec-level model.
  task automatic test_random();
    int st [RN];
    int wr, rd, fid, cid, fcnt;
    bit fa, ca, fg, cg, er;
    bit do_fg, do_fd, do_cg, do_cd;
    logic [12:0] got, exp;
    r_flush = 1'b1; tick(); r_flush = 1'b0;
    for (int i = 0; i < RN; i++) st[i] = 0;
    wr = 0; rd = 0; fid = 0; cid = 0; fa = 0; ca = 0; fg = 0; cg = 0; er = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r_fill_req     = ($urandom_range(0, 3) != 0);
      r_consume_req  = ($urandom_range(0, 3) != 0);
      r_fill_done    = fa ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      r_consume_done = ca ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      r_flush        = ($urandom_range(0, 60) == 0);
      if (r_flush) begin
        for (int i = 0; i < RN; i++) st[i] = 0;
        wr = 0; rd = 0; fid = 0; cid = 0; fa = 0; ca = 0; fg = 0; cg = 0; er = 0;
      end else begin
        do_fg = r_fill_req && !fa && st[wr] == 0;
        do_fd = r_fill_done && fa;
        do_cg = r_consume_req && !ca && st[rd] == 2;
        do_cd = r_consume_done && ca;
        if ((r_fill_done && !fa) || (r_consume_done && !ca)) er = 1;
        fg = do_fg;
        cg = do_cg;
        if (do_fg) begin st[wr] = 1; fa = 1; fid = wr; end
        if (do_fd) begin st[fid] = 2; fa = 0; wr = (wr + 1) % RN; end
        if (do_cg) begin st[rd] = 3; ca = 1; cid = rd; end
        if (do_cd) begin st[cid] = 0; ca = 0; rd = (rd + 1) % RN; end
      end
      tick();
      fcnt = 0;
      foreach (st[i]) if (st[i] == 2) fcnt++;
      exp = {fg, fa, 2'(fid), cg, ca, 2'(cid), 2'(fcnt), (fcnt == 0 && !fa && !ca), er};
      got = {r_fill_grant, r_fill_active, r_fill_id, r_consume_grant, r_consume_active, r_consume_id,
             r_full_count, r_all_empty, r_perr};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b want %b (fg fa fid cg ca cid cnt empty err)", cyc, got, exp);
      end
    end
    r_flush = 0; r_fill_req = 0; r_fill_done = 0; r_consume_req = 0; r_consume_done = 0;
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_backpressure();
    test_overlap();
    test_empty_ring();
    test_protocol_error();
    test_flush_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
